// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states and the grant encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: D has priority unless I has been starved to the limit.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic starved,
    output logic any_req,
    output logic pick_d
);

    grant_t winner;

    always_comb begin
        winner = GRANT_I;
        if (d_req && !(i_req && starved)) begin
            winner = GRANT_D;
        end
        any_req = i_req | d_req;
        pick_d  = (winner == GRANT_D);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch (I) and data (D) ports,
// one transaction in flight, fixed D>I priority with a starvation guard for I.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LAT_W = $clog2(MEM_LATENCY + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    grant_t            grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [STV_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic any_req;
    logic pick_d;
    logic starved;

    assign starved = (starve_cnt_q == STV_MAX);

    mem_arb_pick u_pick (
        .i_req   (i_req),
        .d_req   (d_req),
        .starved (starved),
        .any_req (any_req),
        .pick_d  (pick_d)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d  = ISSUE;
                    mem_en_d = 1'b1;
                    if (pick_d) begin
                        grant_d  = GRANT_D;
                        we_d     = d_we;
                        addr_d   = d_addr;
                        wdata_d  = d_wdata;
                        mem_we_d = d_we;
                    end else begin
                        grant_d  = GRANT_I;
                        we_d     = 1'b0;
                        addr_d   = i_addr;
                        wdata_d  = '0;
                    end
                    // Count only grants that actually made I wait; saturate at the limit.
                    if (pick_d && i_req) begin
                        starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + 1'b1;
                    end else begin
                        starve_cnt_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d   = DONE;
                    i_ready_d = (grant_q == GRANT_I);
                    d_ready_d = (grant_q == GRANT_D);
                end else begin
                    state_d   = WAIT;
                    lat_cnt_d = LAT_LOAD;
                end
            end
            WAIT: begin
                if (lat_cnt_q == LAT_ONE) begin
                    state_d   = DONE;
                    i_ready_d = (grant_q == GRANT_I);
                    d_ready_d = (grant_q == GRANT_D);
                    if (grant_q == GRANT_D) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        i_rdata_d = mem_rdata;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= GRANT_I;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Memory-side outputs come only from flops, never from the request inputs.
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
